// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller, ALU and datapath:
// state and class encodings, opcode/func constants, ALU and PC-source codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_RTYPE   = 3'd1,
        CL_ADDI    = 3'd2,
        CL_LW      = 3'd3,
        CL_SW      = 3'd4,
        CL_BEQ     = 3'd5,
        CL_J       = 3'd6
    } class_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_SLT = 6'h2A;

    function automatic logic is_mem_class(input class_e c);
        return (c == CL_LW) || (c == CL_SW);
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier: maps opc/func to an instruction class
// and, for R-type, the ALU operation selected by func.
module instr_class_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opc,
    input  logic [5:0] func,
    output class_e     cls,
    output alu_op_e    r_op,
    output logic       illegal
);

    // Opcode table; unknown opcodes and unknown R-type funcs are illegal
    always_comb begin
        cls  = CL_ILLEGAL;
        r_op = ALU_ADD;
        case (opc)
            OPC_RTYPE: begin
                case (func)
                    FUNC_ADD: begin cls = CL_RTYPE; r_op = ALU_ADD; end
                    FUNC_SUB: begin cls = CL_RTYPE; r_op = ALU_SUB; end
                    FUNC_AND: begin cls = CL_RTYPE; r_op = ALU_AND; end
                    FUNC_OR:  begin cls = CL_RTYPE; r_op = ALU_OR;  end
                    FUNC_SLT: begin cls = CL_RTYPE; r_op = ALU_SLT; end
                    default:  begin cls = CL_ILLEGAL; r_op = ALU_ADD; end
                endcase
            end
            OPC_ADDI: cls = CL_ADDI;
            OPC_LW:   cls = CL_LW;
            OPC_SW:   cls = CL_SW;
            OPC_BEQ:  cls = CL_BEQ;
            OPC_J:    cls = CL_J;
            default:  cls = CL_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory wait
// watchdog that parks the block in ERROR until reset.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       alu_src_b,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       illegal,
    output logic       err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    state_e        state_q, state_d;
    class_e        class_q, class_d;
    alu_op_e       rop_q, rop_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          run_q, run_d;

    class_e        dec_cls_s;
    alu_op_e       dec_rop_s;
    logic          dec_illegal_s;
    logic          wait_timeout_s;

    instr_class_dec u_dec (
        .opc     (opc),
        .func    (func),
        .cls     (dec_cls_s),
        .r_op    (dec_rop_s),
        .illegal (dec_illegal_s)
    );

    // The limit is hit on the cycle the counter would reach MAX_WAIT; a
    // same-cycle mem_ready wins because the ready branches are tested first.
    assign wait_timeout_s = mem_req && !mem_ready && (wait_q == WAIT_LAST);

    // Next-state, class latch and wait counter
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        rop_d   = rop_q;
        run_d   = 1'b1;
        case (state_q)
            ST_FETCH: begin
                if (run_q && mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_timeout_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                class_d = dec_cls_s;
                rop_d   = dec_rop_s;
                if (dec_illegal_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_mem_class(class_q)) begin
                    state_d = ST_MEM;
                end else if ((class_q == CL_RTYPE) || (class_q == CL_ADDI)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CL_LW) ? ST_WB : ST_FETCH;
                end else if (wait_timeout_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        if (state_d != state_q) begin
            wait_d = {CW{1'b0}};
        end else if (mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = wait_q;
        end
    end

    // run_q holds the outputs quiet for the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= CL_ILLEGAL;
            rop_q   <= ALU_ADD;
            wait_q  <= {CW{1'b0}};
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            rop_q   <= rop_d;
            wait_q  <= wait_d;
            run_q   <= run_d;
        end
    end

    assign state = state_q;

    // Output decode from state and latched class; FETCH and BEQ terms are Mealy
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alu_src_b  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        pc_src     = PC_SRC_SEQ;
        illegal    = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = run_q;
                ir_we   = run_q && mem_ready;
                pc_we   = run_q && mem_ready;
            end
            ST_DECODE: illegal = dec_illegal_s;
            ST_EXEC: begin
                case (class_q)
                    CL_RTYPE: alu_op = rop_q;
                    CL_ADDI, CL_LW, CL_SW: begin
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                    end
                    CL_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_src = PC_SRC_BRANCH;
                        pc_we  = alu_zero;
                    end
                    CL_J: begin
                        pc_src = PC_SRC_JUMP;
                        pc_we  = 1'b1;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (class_q == CL_SW);
            end
            ST_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (class_q == CL_RTYPE);
                mem_to_reg = (class_q == CL_LW);
            end
            ST_ERROR: err = 1'b1;
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model pushes the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    localparam int MW = 15;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opc = 6'h00, func = 6'h00;
    logic       alu_zero = 1'b0, mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_req, mem_we, iord, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic       illegal, err;

    typedef struct packed {
        logic pc_we, ir_we, reg_we, mem_req, mem_we, iord, alu_src_b, reg_dst, mem_to_reg;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [2:0] state;
        logic illegal, err;
    } outv_t;

    typedef struct {
        outv_t exp;
        outv_t care;
        int    id;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    failures = 0;
    int    instr_no = 0;
    int    omap [logic [5:0]];
    int    fmap [logic [5:0]];
    exp_t  mon_x;
    outv_t mon_a;

    multicycle_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .func(func),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    // Selects are only meaningful where they steer something
    function automatic outv_t care_of(input outv_t e, input bit in_rst);
        outv_t c;
        c = '1;
        if (!in_rst) begin
            if (e.state != 3'd2) begin c.alu_op = 3'd0; c.alu_src_b = 1'b0; end
            if (!e.pc_we) c.pc_src = 2'd0;
            if (!e.mem_req) c.iord = 1'b0;
            if (e.state != 3'd4) c.mem_to_reg = 1'b0;
        end
        return c;
    endfunction

    function automatic outv_t st_only(input logic [2:0] s);
        outv_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 18) return 0;
        else if (r < 28) return int'($urandom_range(1, 4));
        else if (r < 30) return MW - 1;
        else return MW;
    endfunction

    task automatic step(input logic mr, input logic z, input outv_t e, input bit in_rst);
        exp_t x;
        mem_ready = mr;
        alu_zero  = z;
        x.exp  = e;
        x.care = care_of(e, in_rst);
        x.id   = instr_no;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step(rnd1(), rnd1(), st_only(3'd0), 1'b1);
        rst_n = 1'b1;
        step(rnd1(), rnd1(), st_only(3'd0), 1'b1);
    endtask

    task automatic error_then_reset();
        outv_t e;
        e = st_only(3'd5);
        e.err = 1'b1;
        for (int i = 0; i < 3; i++) step(rnd1(), rnd1(), e, 1'b0);
        do_reset(2);
    endtask

    // Instruction-level reference: df/dm are wait cycles before mem_ready in FETCH/MEM
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int df,
                             input int dm, input logic z, input int rst_at_mem);
        int    k;
        int    rop;
        outv_t e;
        bit    to;
        instr_no++;
        k   = K_ILL;
        rop = 0;
        if (omap.exists(o)) k = omap[o];
        if (k == K_R) begin
            if (fmap.exists(f)) rop = fmap[f];
            else k = K_ILL;
        end
        to = 1'b0;
        for (int w = 0; w <= df; w++) begin
            if (w == MW) begin to = 1'b1; break; end
            e = st_only(3'd0);
            e.mem_req = 1'b1;
            e.ir_we = (w == df);
            e.pc_we = (w == df);
            step(w == df, rnd1(), e, 1'b0);
        end
        if (to) begin error_then_reset(); return; end

        opc = o;
        func = f;
        e = st_only(3'd1);
        e.illegal = (k == K_ILL);
        step(rnd1(), rnd1(), e, 1'b0);
        if (k == K_ILL) return;

        e = st_only(3'd2);
        case (k)
            K_R: e.alu_op = 3'(rop);
            K_ADDI, K_LW, K_SW: e.alu_src_b = 1'b1;
            K_BEQ: begin e.alu_op = 3'd1; e.pc_we = z; e.pc_src = 2'd1; end
            K_J: begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
            default: e.alu_op = 3'd0;
        endcase
        step(rnd1(), z, e, 1'b0);
        if (k == K_BEQ || k == K_J) return;

        if (k == K_LW || k == K_SW) begin
            for (int w = 0; w <= dm; w++) begin
                if (w == rst_at_mem) begin do_reset(2); return; end
                if (w == MW) begin to = 1'b1; break; end
                e = st_only(3'd3);
                e.mem_req = 1'b1;
                e.iord = 1'b1;
                e.mem_we = (k == K_SW);
                step(w == dm, rnd1(), e, 1'b0);
            end
            if (to) begin error_then_reset(); return; end
            if (k == K_SW) return;
        end

        e = st_only(3'd4);
        e.reg_we = 1'b1;
        e.reg_dst = (k == K_R);
        e.mem_to_reg = (k == K_LW);
        step(rnd1(), rnd1(), e, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_x = sb_q.pop_front();
            mon_a = {pc_we, ir_we, reg_we, mem_req, mem_we, iord, alu_src_b, reg_dst,
                     mem_to_reg, alu_op, pc_src, state, illegal, err};
            checks++;
            if (((mon_a ^ mon_x.exp) & mon_x.care) != '0) begin
                failures++;
                $display("FAIL outputs instr=%0d exp_state=%0d actual=%05h required=%05h care=%05h",
                         mon_x.id, mon_x.exp.state, mon_a, mon_x.exp, mon_x.care);
            end
        end
    end

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] rf [5];
        int         sel;
        omap[6'h00] = K_R;   omap[6'h08] = K_ADDI; omap[6'h23] = K_LW;
        omap[6'h2B] = K_SW;  omap[6'h04] = K_BEQ;  omap[6'h02] = K_J;
        fmap[6'h20] = 0; fmap[6'h22] = 1; fmap[6'h24] = 2; fmap[6'h25] = 3; fmap[6'h2A] = 4;
        rf[0] = 6'h20; rf[1] = 6'h22; rf[2] = 6'h24; rf[3] = 6'h25; rf[4] = 6'h2A;

        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(6'h00, 6'h20, 0, 0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, -1);
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, -1);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, -1);
        run_instr(6'h08, 6'h11, MW - 1, 0, 1'b0, -1);
        run_instr(6'h00, 6'h22, MW, 0, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 0, 3, 1'b0, 2);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1, MW - 1, 1'b0, -1);
        run_instr(6'h23, 6'h00, 0, MW, 1'b0, -1);

        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            f = 6'($urandom_range(0, 63));
            case (sel)
                0, 1, 2: begin o = 6'h00; f = rf[$urandom_range(0, 4)]; end
                3: o = 6'h08;
                4: o = 6'h23;
                5: o = 6'h2B;
                6: o = 6'h04;
                7: o = 6'h02;
                8: begin
                    o = 6'($urandom_range(0, 63));
                    while (omap.exists(o)) o = 6'($urandom_range(0, 63));
                end
                default: begin
                    o = 6'h00;
                    while (fmap.exists(f)) f = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(o, f, rnd_delay(), rnd_delay(), rnd1(),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15, the number of consecutive cycles mem_req may stay unanswered before a timeout.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port opc  input  6  instruction bits 31:26 from the instruction split logic.
REQ-005 The block SHALL have port func  input  6  instruction bits 5:0 from the instruction split logic.
REQ-006 The block SHALL have port alu_zero  input  1  ALU zero flag, valid in EXEC.
REQ-007 The block SHALL have port mem_ready  input  1  memory completes the current request.
REQ-008 The block SHALL have outputs pc_we, ir_we, reg_we, mem_req, mem_we, iord, alu_src_b, reg_dst, mem_to_reg  output  1 each  datapath strobes and selects.
REQ-009 The block SHALL have outputs alu_op  output  3  (0 add, 1 sub, 2 and, 3 or, 4 slt); pc_src  output  2  (0 pc+4, 1 branch, 2 jump); state  output  3; illegal  output  1; err  output  1.

Function
REQ-010 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5; outputs are Moore-decoded from state plus the latched class, except where REQ-013 and REQ-015 say otherwise.
REQ-011 FETCH SHALL assert mem_req with iord=0 and hold it until mem_ready; in the cycle mem_ready=1 it SHALL pulse ir_we and pc_we (pc_src=0) and go to DECODE.
REQ-012 DECODE SHALL last one cycle and register the class from opc/func: R-type (opc 0x00; func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02; any other code is ILLEGAL.
REQ-013 ILLEGAL SHALL pulse illegal for one cycle in DECODE and return to FETCH with no write strobes.
REQ-014 EXEC SHALL drive alu_op per class (R by func, ADDI/LW/SW add, BEQ sub) and alu_src_b=1 for ADDI/LW/SW; R/ADDI go to WB, LW/SW go to MEM.
REQ-015 In EXEC, BEQ SHALL assert pc_we with pc_src=1 only when alu_zero=1 (Mealy); J SHALL assert pc_we with pc_src=2; both return to FETCH.
REQ-016 MEM SHALL assert mem_req with iord=1, and mem_we=1 for SW; on mem_ready SW goes to FETCH and LW goes to WB.
REQ-017 WB SHALL pulse reg_we for one cycle, with reg_dst=1 for R-type and mem_to_reg=1 for LW, then go to FETCH.
REQ-018 Latency from the FETCH entry, with mem_ready always 1, SHALL be: R/ADDI/SW 4 cycles, LW 5, BEQ/J 3, ILLEGAL 2.
REQ-019 A wait counter SHALL clear on each state entry and increment each cycle while mem_req=1 and mem_ready=0.
REQ-020 When the wait counter reaches MAX_WAIT, the block SHALL go to ERROR.
REQ-021 ERROR SHALL hold err=1 with all strobes 0 until reset; mem_ready arriving in the same cycle as the limit is reached SHALL count as success.
REQ-022 The mem_ready input SHALL be ignored outside FETCH and MEM.

Reset
REQ-023 While rst_n=0 the block SHALL immediately force state FETCH, the class register to ILLEGAL, the wait counter to 0, and every output to 0 except state=0.
REQ-024 Reset mid-operation (for example in MEM with mem_we asserted) SHALL drop all strobes asynchronously.
REQ-025 After reset, the block SHALL restart with FETCH asserting mem_req in the first clock after rst_n rises.

Structure
REQ-026 State encodings, opcode/func constants, alu_op codes and pc_src codes SHALL live in a shared package ctrl_pkg, also used by the ALU and datapath.
REQ-027 Opcode/func classification SHALL be a combinational sub-module instr_class_dec, instantiated once; the state machine SHALL be in multicycle_ctrl.

Verification
REQ-028 The bench SHALL cover: opc=0x00, func=0x20, mem_ready=1 -> states 0,1,2,4; reg_we=1 and reg_dst=1 in cycle 4 only; alu_op=0.
REQ-029 The bench SHALL cover: opc=0x23, mem_ready delayed 3 cycles in MEM -> mem_req=1 and iord=1 for 4 cycles; reg_we and mem_to_reg in the following WB.
REQ-030 The bench SHALL cover: opc=0x04, alu_zero=1 then 0 -> pc_we=1 with pc_src=1 in EXEC only for the first instruction; 3 cycles each.
REQ-031 The bench SHALL cover: opc=0x3F -> illegal pulse in DECODE; no pc_we, reg_we or mem_we after the fetch; next FETCH follows.
REQ-032 The bench SHALL cover: mem_ready held 0 in FETCH with MAX_WAIT=15 -> ERROR and err=1 after 15 cycles; mem_ready on exactly cycle 15 -> DECODE instead.
REQ-033 The bench SHALL cover: rst_n dropped in MEM during SW -> mem_we and mem_req fall before the next clock; after release, a fresh FETCH starts.
